// File: rtl/multi_bank_cmd_scheduler_pkg.sv
// multi_bank_cmd_scheduler_pkg: global widths, bank/command types and the state-to-command decode.
// Widths are macros so the issue FIFO and bank FSM array can share them.
`ifndef MULTI_BANK_CMD_SCHEDULER_DEFINES
`define MULTI_BANK_CMD_SCHEDULER_DEFINES
`define FSM_WIDTH2 4
`define ADDR_BITS 14
`define BA_BITS 3
`define ISU_FIFO_WIDTH (4 + `BA_BITS + `ADDR_BITS)
`endif

package multi_bank_cmd_scheduler_pkg;
    typedef enum logic [`FSM_WIDTH2-1:0] {
        B_IDLE, B_ACTIVE, B_READ, B_WRITE, B_READA, B_WRITEA,
        B_PRE, B_PREA, B_REFRESH_CHECK, B_WAIT
    } bank_state_t;
    typedef enum logic [3:0] {
        ATCMD_NOP, ATCMD_ACTIVE, ATCMD_READ, ATCMD_WRITE, ATCMD_RDA,
        ATCMD_WRA, ATCMD_PRE, ATCMD_PREA, ATCMD_REFRESH
    } sch_cmd_t;
    typedef enum logic {DIR_WRITE = 1'b0, DIR_READ = 1'b1} r_w_t;
    typedef enum logic [2:0] {
        CLS_REFRESH, CLS_AGED, CLS_CAS_CUR, CLS_ACTIVE, CLS_PRE, CLS_CAS_OPP
    } sch_class_t;
    localparam int NUM_CLS = 6;

    function automatic sch_cmd_t state2cmd(input bank_state_t s);
        case (s)
            B_ACTIVE:        return ATCMD_ACTIVE;
            B_READ:          return ATCMD_READ;
            B_WRITE:         return ATCMD_WRITE;
            B_READA:         return ATCMD_RDA;
            B_WRITEA:        return ATCMD_WRA;
            B_PRE:           return ATCMD_PRE;
            B_PREA:          return ATCMD_PREA;
            B_REFRESH_CHECK: return ATCMD_REFRESH;
            default:         return ATCMD_NOP;
        endcase
    endfunction
endpackage

// File: rtl/multi_bank_cmd_scheduler_if.sv
// multi_bank_cmd_scheduler_if: bank FSM array / issue FIFO side signals of the scheduler.
interface multi_bank_cmd_scheduler_if #(parameter int NUM_BANKS = 4, parameter int ADDR_W = `ADDR_BITS);
    logic                            isu_fifo_full;
    logic [NUM_BANKS*`FSM_WIDTH2-1:0] ba_state;
    logic [NUM_BANKS*ADDR_W-1:0]     ba_addr;
    logic [NUM_BANKS-1:0]            ba_stall;
    logic [`ISU_FIFO_WIDTH-1:0]      sch_out;
    logic                            sch_issue;
    modport master(input isu_fifo_full, ba_state, ba_addr, output ba_stall, sch_out, sch_issue);
    modport slave(output isu_fifo_full, ba_state, ba_addr, input ba_stall, sch_out, sch_issue);
endinterface

// File: rtl/multi_bank_cmd_scheduler_sched_rr_arbiter.sv
// sched_rr_arbiter: one-hot round-robin pick, searching upward from ptr with wraparound.
module sched_rr_arbiter #(parameter int N = 4) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    logic [N-1:0] rot, oh;
    // rotate so ptr sits at bit 0, take the lowest set bit, rotate back
    assign rot   = N'({req, req} >> ptr);
    assign oh    = rot & (~rot + N'(1));
    assign grant = N'(({oh, oh} << ptr) >> N);
endmodule

// File: rtl/multi_bank_cmd_scheduler.sv
// multi_bank_cmd_scheduler: grants one bank FSM per cycle into the issue FIFO with class priority,
// round-robin fairness, read/write grouping and starvation aging. CMD_SCH_STATS_EN adds stat counters.
module multi_bank_cmd_scheduler import multi_bank_cmd_scheduler_pkg::*; #(
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_W     = `ADDR_BITS,
    parameter int BA_W       = `BA_BITS,
    parameter int AGE_W      = 8,
    parameter int AGE_THRESH = 16,
    parameter int RW_BURST   = 4
) (
    input logic clk,
    input logic rst,
    multi_bank_cmd_scheduler_if.master bus
`ifdef CMD_SCH_STATS_EN
    ,
    output logic [15:0] stat_issue_cnt,
    output logic [15:0] stat_full_cnt
`endif
);
    localparam int FW = `FSM_WIDTH2;
    localparam int PW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(RW_BURST + 1);

    bank_state_t          st [NUM_BANKS];
    bank_state_t          sel_st;
    logic [NUM_BANKS-1:0] req, is_rd, is_wr, is_ref, is_act, is_pre, aged, cas_cur, cas_opp, grant;
    logic [NUM_BANKS-1:0] cls_req [NUM_CLS];
    logic [NUM_BANKS-1:0] cls_gnt [NUM_CLS];
    logic [AGE_W-1:0]     age_q [NUM_BANKS];
    logic [ADDR_W-1:0]    sel_addr;
    logic [PW-1:0]        rr_ptr, gidx;
    logic [CW-1:0]        rw_cnt, rw_d;
    logic                 cur_pend, opp_pend, switch_dir, gcas;
    r_w_t                 cur_dir, dir_d;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_dec
        assign st[b]     = bank_state_t'(bus.ba_state[b*FW +: FW]);
        assign is_rd[b]  = st[b] == B_READ || st[b] == B_READA;
        assign is_wr[b]  = st[b] == B_WRITE || st[b] == B_WRITEA;
        assign is_ref[b] = st[b] == B_REFRESH_CHECK || st[b] == B_PREA;
        assign is_act[b] = st[b] == B_ACTIVE;
        assign is_pre[b] = st[b] == B_PRE;
        assign req[b]    = is_rd[b] | is_wr[b] | is_ref[b] | is_act[b] | is_pre[b];
        assign aged[b]   = req[b] && !is_ref[b] && age_q[b] > AGE_W'(AGE_THRESH);
    end

    // direction switch takes effect in the same cycle so a burst never exceeds RW_BURST
    always_comb begin
        cur_pend   = cur_dir == DIR_READ ? |is_rd : |is_wr;
        opp_pend   = cur_dir == DIR_READ ? |is_wr : |is_rd;
        switch_dir = opp_pend && (!cur_pend || rw_cnt == CW'(RW_BURST));
        dir_d      = switch_dir ? (cur_dir == DIR_READ ? DIR_WRITE : DIR_READ) : cur_dir;
    end

    always_comb begin
        cas_cur               = dir_d == DIR_READ ? is_rd : is_wr;
        cas_opp               = dir_d == DIR_READ ? is_wr : is_rd;
        cls_req               = '{default: '0};
        cls_req[CLS_REFRESH]  = is_ref;
        cls_req[CLS_AGED]     = aged;
        cls_req[CLS_CAS_CUR]  = cas_cur & ~aged;
        cls_req[CLS_ACTIVE]   = is_act & ~aged;
        cls_req[CLS_PRE]      = is_pre & ~aged;
        cls_req[CLS_CAS_OPP]  = cas_opp & ~aged;
    end

    for (genvar c = 0; c < NUM_CLS; c++) begin : g_cls
        sched_rr_arbiter #(.N(NUM_BANKS)) u_arb (.req(cls_req[c]), .ptr(rr_ptr), .grant(cls_gnt[c]));
    end

    always_comb begin
        grant = '0;
        for (int c = NUM_CLS - 1; c >= 0; c--)
            if (|cls_req[c]) grant = cls_gnt[c];
        if (bus.isu_fifo_full) grant = '0;
        gidx     = '0;
        sel_st   = B_IDLE;
        sel_addr = '0;
        for (int i = 0; i < NUM_BANKS; i++)
            if (grant[i]) begin
                gidx     = PW'(i);
                sel_st   = st[i];
                sel_addr = bus.ba_addr[i*ADDR_W +: ADDR_W];
            end
        gcas = |(grant & cas_cur);
        rw_d = switch_dir ? CW'(gcas) : (gcas && rw_cnt != CW'(RW_BURST)) ? rw_cnt + CW'(1) : rw_cnt;
    end

    assign bus.ba_stall = ~grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.sch_issue <= 1'b0;
            bus.sch_out   <= '0;
            rr_ptr        <= '0;
            cur_dir       <= DIR_WRITE;
            rw_cnt        <= '0;
            for (int i = 0; i < NUM_BANKS; i++) age_q[i] <= '0;
        end else begin
            bus.sch_issue <= |grant;
            bus.sch_out   <= |grant ? {state2cmd(sel_st), BA_W'(gidx), sel_addr} : '0;
            if (|grant) rr_ptr <= gidx == PW'(NUM_BANKS - 1) ? '0 : gidx + PW'(1);
            cur_dir       <= dir_d;
            rw_cnt        <= rw_d;
            for (int i = 0; i < NUM_BANKS; i++)
                age_q[i] <= (!req[i] || grant[i]) ? '0 : (&age_q[i]) ? age_q[i] : age_q[i] + AGE_W'(1);
        end
    end

`ifdef CMD_SCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issue_cnt <= '0;
            stat_full_cnt  <= '0;
        end else begin
            if (bus.sch_issue && !(&stat_issue_cnt)) stat_issue_cnt <= stat_issue_cnt + 16'd1;
            if (bus.isu_fifo_full && |req && !(&stat_full_cnt)) stat_full_cnt <= stat_full_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_multi_bank_cmd_scheduler.sv
// tb_multi_bank_cmd_scheduler: directed scenarios for the multi-bank command scheduler.
module tb_multi_bank_cmd_scheduler;
    import multi_bank_cmd_scheduler_pkg::*;
    localparam int AW = `ADDR_BITS;
    localparam int BW = `BA_BITS;
    localparam int FW = `FSM_WIDTH2;

    logic clk, rst;
    int checks, failures;
    logic [3:0]    cmd;
    logic [BW-1:0] bank;
    logic [AW-1:0] addr;

    multi_bank_cmd_scheduler_if #(.NUM_BANKS(4), .ADDR_W(AW)) bus();
`ifdef CMD_SCH_STATS_EN
    logic [15:0] stat_issue_cnt, stat_full_cnt;
`endif

    multi_bank_cmd_scheduler #(.NUM_BANKS(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef CMD_SCH_STATS_EN
        ,
        .stat_issue_cnt(stat_issue_cnt),
        .stat_full_cnt(stat_full_cnt)
`endif
    );

    assign {cmd, bank, addr} = bus.sch_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_bank(input int b, input bank_state_t s, input logic [AW-1:0] a);
        bus.ba_state[b*FW +: FW] = s;
        bus.ba_addr[b*AW +: AW]  = a;
    endtask

    task automatic idle_all();
        bus.ba_state = '0;
        bus.ba_addr  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_all();
        bus.isu_fifo_full = 1'b0;
        rst = 1'b1;
        #3;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (bus.sch_issue !== 1'b0) begin failures++; $display("FAIL reset_issue got=%0b exp=0", bus.sch_issue); end
        checks++; if (bus.sch_out !== '0) begin failures++; $display("FAIL reset_out got=%0h exp=0", bus.sch_out); end
        checks++; if (bus.ba_stall !== 4'b1111) begin failures++; $display("FAIL reset_stall got=%b exp=1111", bus.ba_stall); end
        checks++; if (dut.cur_dir !== DIR_WRITE) begin failures++; $display("FAIL reset_dir got=%0d exp=0", dut.cur_dir); end
        checks++; if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dut.rr_ptr); end
    endtask

    task automatic test_single_grant();
        do_reset();
        set_bank(2, B_ACTIVE, 14'h123);
        #1;
        checks++; if (bus.ba_stall !== 4'b1011) begin failures++; $display("FAIL single_stall got=%b exp=1011", bus.ba_stall); end
        tick();
        checks++; if (bus.sch_issue !== 1'b1) begin failures++; $display("FAIL single_issue got=%0b exp=1", bus.sch_issue); end
        checks++; if (cmd !== ATCMD_ACTIVE) begin failures++; $display("FAIL single_cmd got=%0d exp=%0d", cmd, ATCMD_ACTIVE); end
        checks++; if (bank !== 3'd2) begin failures++; $display("FAIL single_bank got=%0d exp=2", bank); end
        checks++; if (addr !== 14'h123) begin failures++; $display("FAIL single_addr got=%0h exp=123", addr); end
        idle_all();
        tick();
        checks++; if (bus.sch_issue !== 1'b0) begin failures++; $display("FAIL single_idle_issue got=%0b exp=0", bus.sch_issue); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_stall;
        do_reset();
        for (int b = 0; b < 4; b++) set_bank(b, B_ACTIVE, AW'(b + 16));
        for (int k = 0; k < 4; k++) begin
            exp_stall = ~(4'b0001 << k);
            #1;
            checks++; if (bus.ba_stall !== exp_stall) begin failures++; $display("FAIL rr_stall%0d got=%b exp=%b", k, bus.ba_stall, exp_stall); end
            tick();
            checks++; if (bus.sch_issue !== 1'b1 || bank !== BW'(k) || addr !== AW'(k + 16))
                begin failures++; $display("FAIL rr_grant%0d got=%0b/%0d/%0h exp=1/%0d/%0h", k, bus.sch_issue, bank, addr, k, k + 16); end
        end
        checks++; if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL rr_wrap got=%0d exp=0", dut.rr_ptr); end
    endtask

    task automatic test_refresh_priority();
        do_reset();
        set_bank(0, B_READ, 14'h10);
        set_bank(1, B_REFRESH_CHECK, 14'h20);
        #1;
        checks++; if (bus.ba_stall !== 4'b1101) begin failures++; $display("FAIL ref_stall got=%b exp=1101", bus.ba_stall); end
        tick();
        checks++; if (cmd !== ATCMD_REFRESH || bank !== 3'd1) begin failures++; $display("FAIL ref_first got=%0d/%0d exp=%0d/1", cmd, bank, ATCMD_REFRESH); end
        set_bank(1, B_IDLE, '0);
        tick();
        checks++; if (cmd !== ATCMD_READ || bank !== 3'd0) begin failures++; $display("FAIL ref_then_read got=%0d/%0d exp=%0d/0", cmd, bank, ATCMD_READ); end
        checks++; if (dut.cur_dir !== DIR_READ) begin failures++; $display("FAIL ref_dir got=%0d exp=1", dut.cur_dir); end
    endtask

    task automatic test_rw_grouping();
        int exp_bank[5];
        sch_cmd_t exp_cmd[5];
        exp_bank = '{0, 1, 0, 1, 2};
        exp_cmd  = '{ATCMD_WRITE, ATCMD_WRITE, ATCMD_WRITE, ATCMD_WRITE, ATCMD_READ};
        do_reset();
        set_bank(0, B_WRITE, 14'h1);
        set_bank(1, B_WRITE, 14'h2);
        set_bank(2, B_READ, 14'h3);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.sch_issue !== 1'b1 || cmd !== exp_cmd[k] || bank !== BW'(exp_bank[k]))
                begin failures++; $display("FAIL rw_seq%0d got=%0b/%0d/%0d exp=1/%0d/%0d", k, bus.sch_issue, cmd, bank, exp_cmd[k], exp_bank[k]); end
        end
        checks++; if (dut.cur_dir !== DIR_READ) begin failures++; $display("FAIL rw_dir got=%0d exp=1", dut.cur_dir); end
    endtask

    task automatic test_aging();
        do_reset();
        bus.isu_fifo_full = 1'b1;
        set_bank(3, B_PRE, 14'h33);
        for (int k = 0; k < 20; k++) begin
            #1;
            checks++; if (bus.ba_stall !== 4'b1111) begin failures++; $display("FAIL age_stall%0d got=%b exp=1111", k, bus.ba_stall); end
            tick();
            checks++; if (bus.sch_issue !== 1'b0) begin failures++; $display("FAIL age_issue%0d got=%0b exp=0", k, bus.sch_issue); end
        end
        checks++; if (dut.age_q[3] !== 8'd20) begin failures++; $display("FAIL age_value got=%0d exp=20", dut.age_q[3]); end
`ifdef CMD_SCH_STATS_EN
        checks++; if (stat_full_cnt !== 16'd20) begin failures++; $display("FAIL stat_full got=%0d exp=20", stat_full_cnt); end
`endif
        bus.isu_fifo_full = 1'b0;
        set_bank(0, B_ACTIVE, 14'h44);
        #1;
        checks++; if (bus.ba_stall !== 4'b0111) begin failures++; $display("FAIL age_win_stall got=%b exp=0111", bus.ba_stall); end
        tick();
        checks++; if (cmd !== ATCMD_PRE || bank !== 3'd3 || addr !== 14'h33)
            begin failures++; $display("FAIL age_win got=%0d/%0d/%0h exp=%0d/3/33", cmd, bank, addr, ATCMD_PRE); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_bank(0, B_READ, 14'h5);
        tick();
        checks++; if (bus.sch_issue !== 1'b1 || dut.cur_dir !== DIR_READ)
            begin failures++; $display("FAIL mid_pre got=%0b/%0d exp=1/1", bus.sch_issue, dut.cur_dir); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.sch_issue !== 1'b0) begin failures++; $display("FAIL mid_issue got=%0b exp=0", bus.sch_issue); end
        checks++; if (bus.sch_out !== '0) begin failures++; $display("FAIL mid_out got=%0h exp=0", bus.sch_out); end
        checks++; if (dut.cur_dir !== DIR_WRITE) begin failures++; $display("FAIL mid_dir got=%0d exp=0", dut.cur_dir); end
        checks++; if (dut.rr_ptr !== 2'd0) begin failures++; $display("FAIL mid_ptr got=%0d exp=0", dut.rr_ptr); end
        checks++; if (bus.ba_stall !== 4'b1110) begin failures++; $display("FAIL mid_stall got=%b exp=1110", bus.ba_stall); end
`ifdef CMD_SCH_STATS_EN
        checks++; if (stat_issue_cnt !== 16'd0 || stat_full_cnt !== 16'd0)
            begin failures++; $display("FAIL mid_stats got=%0d/%0d exp=0/0", stat_issue_cnt, stat_full_cnt); end
`endif
        #1 rst = 1'b0;
        idle_all();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.isu_fifo_full = 1'b0;
        idle_all();
        test_reset();
        test_single_grant();
        test_round_robin();
        test_refresh_priority();
        test_rw_grouping();
        test_aging();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
